// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds multi-digit BCD/hex values by watching a
// multiplexed active-high seven-segment bus. Scan transitions and glitches
// are filtered out by requiring {an, seg} to hold steady before it is accepted.
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid,
    output logic                  frame_done,
    output logic                  err
);

    localparam int PW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 2);
    localparam logic [CW-1:0] RUN_LEN = CW'(STABLE_CYCLES);

    // Sampled bus pattern and the length of its current run. The counter
    // saturates one past RUN_LEN, so a long hold fires only once.
    logic [PW-1:0]            samp;
    logic [CW-1:0]            run_cnt;

    logic [DIGITS-1:0]        mask;
    logic [DIGITS-1:0][3:0]   shadow;
    logic [DIGITS-1:0][3:0]   frame;

    logic [DIGITS-1:0]        an_s;
    logic [6:0]               seg_s;
    logic                     one_hot;
    logic                     legal;
    logic [3:0]               val;
    logic                     fire;
    logic [DIGITS-1:0]        mask_nxt;
    logic [DIGITS-1:0][3:0]   shadow_nxt;

    // {legal, value} for a segment pattern; anything off-table is illegal.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = 5'h10;
            7'h06:   decode = 5'h11;
            7'h5B:   decode = 5'h12;
            7'h4F:   decode = 5'h13;
            7'h66:   decode = 5'h14;
            7'h6D:   decode = 5'h15;
            7'h7D:   decode = 5'h16;
            7'h07:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h6F:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h7C:   decode = 5'h1B;
            7'h39:   decode = 5'h1C;
            7'h5E:   decode = 5'h1D;
            7'h79:   decode = 5'h1E;
            7'h71:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // Decode the qualified pattern and precompute the capture result.
    always_comb begin
        an_s     = samp[PW-1:7];
        seg_s    = samp[6:0];
        one_hot  = (an_s != '0) && ((an_s & (an_s - DIGITS'(1))) == '0);
        {legal, val} = decode(seg_s);
        fire     = (run_cnt == RUN_LEN);
        mask_nxt = mask | an_s;
        for (int i = 0; i < DIGITS; i++)
            shadow_nxt[i] = an_s[i] ? val : shadow[i];
    end

    // Stability filter: any change in {an, seg} restarts the run at one.
    // A zero count (after reset) also forces a fresh run.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp    <= '0;
            run_cnt <= '0;
        end else begin
            samp <= {an, seg};
            if (run_cnt == '0 || {an, seg} != samp)
                run_cnt <= CW'(1);
            else if (run_cnt <= RUN_LEN)
                run_cnt <= run_cnt + CW'(1);
        end
    end

    // Capture into the shadow; publish the frame when every digit is in.
    // Blank or overlapping enables are ignored outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask       <= '0;
            shadow     <= '0;
            frame      <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (fire && one_hot) begin
                if (legal) begin
                    shadow <= shadow_nxt;
                    if (&mask_nxt) begin
                        frame      <= shadow_nxt;
                        valid      <= 1'b1;
                        frame_done <= 1'b1;
                        mask       <= '0;
                    end else begin
                        mask <= mask_nxt;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign bcd_out = frame;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
// Stimulus pushes the expected event (kind, frame value, cycle); a monitor
// pops and compares whenever frame_done or err is seen.
module tb_seg_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    localparam int EV_NONE  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int          kind;
        logic [15:0] bcd;
        int          cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [6:0]            seg = '0;
    logic [DIGITS-1:0]     an  = '0;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  valid;
    logic                  frame_done;
    logic                  err;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .bcd_out    (bcd_out),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Hold {a, s} for n edges; if an event is expected it shows after the
    // (STABLE+1)th edge counted from the first sampled edge.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n,
                        input int kind, input logic [15:0] b);
        exp_t e;
        @(negedge clk);
        an  = a;
        seg = s;
        if (kind != EV_NONE) begin
            e.kind = kind;
            e.bcd  = b;
            e.cyc  = cyc + STABLE + 1;
            sb.push_back(e);
        end
        repeat (n) @(posedge clk);
    endtask

    // Two reset edges with random bus activity; outputs checked after each.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        an  = DIGITS'($urandom);
        seg = 7'($urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_bcd",        32'(bcd_out),    32'h0);
            check("rst_valid",      32'(valid),      32'h0);
            check("rst_frame_done", 32'(frame_done), 32'h0);
            check("rst_err",        32'(err),        32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        an  = '0;
        seg = '0;
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (frame_done || err)) begin
            if (frame_done && err) begin
                miscompares++;
                $display("FAIL both_pulses: frame_done and err together at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: frame_done=%0b err=%0b at cycle %0d, none expected",
                         frame_done, err, cyc);
            end else begin
                e = sb.pop_front();
                check("event_kind", frame_done ? EV_FRAME : EV_ERR, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (e.kind == EV_FRAME) begin
                    check("frame_bcd", 32'(bcd_out), 32'(e.bcd));
                    check("frame_valid", 32'(valid), 32'h1);
                end
            end
        end
    end

    initial begin
        do_reset();

        // Frame assembly: 5,2,0,2 -> 2025
        hold(4'b0001, 7'h6D, 8, EV_NONE,  16'h0);
        hold(4'b0010, 7'h5B, 8, EV_NONE,  16'h0);
        hold(4'b0100, 7'h3F, 8, EV_NONE,  16'h0);
        hold(4'b1000, 7'h5B, 8, EV_FRAME, 16'h2025);
        @(negedge clk);
        check("bcd_between_frames", 32'(bcd_out), 32'h2025);

        // Glitch rejection: short 3 on digit 1 is dropped, 1 is kept
        hold(4'b0010, 7'h4F, 3, EV_NONE,  16'h0);
        hold(4'b0010, 7'h06, 8, EV_NONE,  16'h0);
        hold(4'b0001, 7'h7D, 8, EV_NONE,  16'h0);
        hold(4'b0100, 7'h07, 8, EV_NONE,  16'h0);
        hold(4'b1000, 7'h66, 8, EV_FRAME, 16'h4716);

        // Illegal glyph on digit 1, held long: one err, frame waits for digit 1
        hold(4'b0010, 7'h00, 10, EV_ERR,  16'h0);
        hold(4'b0001, 7'h3F, 8,  EV_NONE, 16'h0);
        hold(4'b0100, 7'h06, 8,  EV_NONE, 16'h0);
        hold(4'b1000, 7'h4F, 8,  EV_NONE, 16'h0);
        hold(4'b0010, 7'h7F, 8,  EV_FRAME, 16'h3180);

        // Blanking and overlap in mid-frame leave the mask alone
        hold(4'b0001, 7'h6F, 8,  EV_NONE, 16'h0);
        hold(4'b0000, 7'h7F, 10, EV_NONE, 16'h0);
        hold(4'b0011, 7'h7F, 10, EV_NONE, 16'h0);
        hold(4'b0010, 7'h77, 8,  EV_NONE, 16'h0);
        hold(4'b0100, 7'h7C, 8,  EV_NONE, 16'h0);
        hold(4'b1000, 7'h39, 8,  EV_FRAME, 16'hCBA9);

        // Hex sweep
        hold(4'b0001, 7'h71, 8, EV_NONE,  16'h0);
        hold(4'b0010, 7'h79, 8, EV_NONE,  16'h0);
        hold(4'b0100, 7'h5E, 8, EV_NONE,  16'h0);
        hold(4'b1000, 7'h77, 8, EV_FRAME, 16'hADEF);

        // Partial frame then reset: earlier captures must be forgotten
        hold(4'b0001, 7'h3F, 8, EV_NONE, 16'h0);
        hold(4'b0010, 7'h06, 8, EV_NONE, 16'h0);
        do_reset();
        hold(4'b0100, 7'h5B, 8, EV_NONE,  16'h0);
        hold(4'b1000, 7'h4F, 8, EV_NONE,  16'h0);
        hold(4'b0001, 7'h66, 8, EV_NONE,  16'h0);
        hold(4'b0010, 7'h6D, 8, EV_FRAME, 16'h3254);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        check("valid_final", 32'(valid), 32'h1);
        check("bcd_final", 32'(bcd_out), 32'h3254);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
